arith_accum_fsm: RTL



---
 rtl/arith_accum_if.sv | 30 +++
 rtl/arith_accum_fsm.sv | 92 +++++++++
 2 files changed

// File: rtl/arith_accum_if.sv
// Operand/result bundle for the accumulating add/subtract engine.
// master drives operands and control; slave is the engine.
interface arith_accum_if #(
  parameter int WIDTH = 12,
  parameter int ACC_W = 16,
  parameter int CNT_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             op_sub;
  logic             accumulate;
  logic             finish;
  logic [ACC_W-1:0] result;
  logic             result_valid;
  logic             overflow;
  logic [CNT_W-1:0] op_count;
  logic             busy;

  modport master (
    output in_valid, op_a, op_b, op_sub, accumulate, finish,
    input  in_ready, result, result_valid, overflow, op_count, busy
  );

  modport slave (
    input  in_valid, op_a, op_b, op_sub, accumulate, finish,
    output in_ready, result, result_valid, overflow, op_count, busy
  );
endinterface

// File: rtl/arith_accum_fsm.sv
// Accumulating add/subtract engine: fresh a op b, or chain +/- b onto the
// running result, with sticky carry/borrow, saturating op counter and result strobe.
module arith_accum_fsm #(
  parameter int WIDTH = 12,
  parameter int ACC_W = 16,
  parameter int CNT_W = 4
) (
  input  logic          clk,
  input  logic          rst,
  arith_accum_if.slave  bus
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_EXEC  = 2'd1;
  localparam logic [1:0] S_ACCUM = 2'd2;
  localparam logic [1:0] S_HOLD  = 2'd3;

  logic [1:0]       state_reg, state_next;
  logic [WIDTH-1:0] a_reg, b_reg;
  logic             sub_reg;
  logic [ACC_W-1:0] result_reg;
  logic             overflow_reg;
  logic             valid_reg;
  logic [CNT_W-1:0] count_reg;

  logic             ready;
  logic             accept;
  logic [ACC_W-1:0] lhs, rhs;
  logic [ACC_W:0]   alu;

  assign ready  = (state_reg == S_IDLE) || (state_reg == S_HOLD);
  assign accept = bus.in_valid & ready;

  // One ALU serves both states; the extra top bit is carry-out for add and
  // borrow for subtract, since both operands are below 2^ACC_W.
  assign lhs = (state_reg == S_ACCUM) ? result_reg : ACC_W'(a_reg);
  assign rhs = ACC_W'(b_reg);
  assign alu = sub_reg ? ({1'b0, lhs} - {1'b0, rhs}) : ({1'b0, lhs} + {1'b0, rhs});

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (accept) state_next = S_EXEC;
      S_EXEC:  state_next = S_HOLD;
      S_ACCUM: state_next = S_HOLD;
      S_HOLD: begin
        // A presented operand takes precedence over finish.
        if (accept)          state_next = bus.accumulate ? S_ACCUM : S_EXEC;
        else if (bus.finish) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= S_IDLE;
      a_reg        <= '0;
      b_reg        <= '0;
      sub_reg      <= 1'b0;
      result_reg   <= '0;
      overflow_reg <= 1'b0;
      valid_reg    <= 1'b0;
      count_reg    <= '0;
    end else begin
      state_reg <= state_next;
      valid_reg <= 1'b0;
      if (accept) begin
        a_reg   <= bus.op_a;
        b_reg   <= bus.op_b;
        sub_reg <= bus.op_sub;
      end
      if (state_reg == S_EXEC) begin
        result_reg   <= alu[ACC_W-1:0];
        overflow_reg <= alu[ACC_W];
        count_reg    <= CNT_W'(1);
        valid_reg    <= 1'b1;
      end else if (state_reg == S_ACCUM) begin
        result_reg   <= alu[ACC_W-1:0];
        overflow_reg <= overflow_reg | alu[ACC_W];
        if (count_reg != '1) count_reg <= count_reg + CNT_W'(1);
        valid_reg    <= 1'b1;
      end
    end
  end

  assign bus.in_ready     = ready;
  assign bus.busy         = ~ready;
  assign bus.result       = result_reg;
  assign bus.result_valid = valid_reg;
  assign bus.overflow     = overflow_reg;
  assign bus.op_count     = count_reg;
endmodule
